disp_rdbuf: RTL

Single-clock display read buffer between the VRAM read controller and the pixel output stage. It captures 64-bit AXI read-data beats as the controller accepts them and stores them in a circular buffer. It returns one 32-bit pixel per pop, as 8-bit R/G/B. It drives `BUF_WREADY` to tell the controller whether another 16-beat burst fits.

---
 rtl/disp_pkg.sv | 30 +++
 rtl/disp_rdbuf_ram.sv | 26 ++
 rtl/disp_rdbuf.sv | 116 +++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared display-path constants: burst length, word/pixel widths and pixel field layout.
package disp_pkg;

    localparam int BURST_LEN = 16;
    localparam int PIX_W     = 32;
    localparam int WORD_W    = 64;

    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Bits [31:24] of a pixel carry no colour and are dropped here.
    function automatic rgb_t pix_to_rgb(input logic [PIX_W-1:0] pix);
        rgb_t c;
        c.r = pix[R_MSB:R_LSB];
        c.g = pix[G_MSB:G_LSB];
        c.b = pix[B_MSB:B_LSB];
        return c;
    endfunction

endpackage

// File: rtl/disp_rdbuf_ram.sv
// DEPTH x 64 simple dual-port storage: registered write port, asynchronous read port.
module disp_rdbuf_ram
    import disp_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              ACLK,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge ACLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/disp_rdbuf.sv
// Display read buffer: captures 64-bit read beats into a circular buffer and pops
// one 32-bit pixel at a time; word pointer plus pixel pointer, no state machine.
module disp_rdbuf
    import disp_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int BURST = BURST_LEN
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic [WORD_W-1:0] RDATA,
    input  logic              RVALID,
    input  logic              RREADY,
    input  logic              FLUSH,
    input  logic              PIX_RE,
    output logic [7:0]        DISP_R,
    output logic [7:0]        DISP_G,
    output logic [7:0]        DISP_B,
    output logic              BUF_WREADY,
    output logic              BUF_EMPTY,
    output logic              OVERFLOW,
    output logic              UNDERRUN
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] BURST_C = (AW+1)'(BURST);

    logic [AW:0]       wptr, wptr_nxt;
    logic [AW+1:0]     rptr, rptr_nxt;
    logic [AW:0]       wcount, wcount_nxt, free_nxt;
    logic              full, empty;
    logic              beat, wr_en, pop_ok;
    logic [WORD_W-1:0] rd_word;
    logic [PIX_W-1:0]  pix;
    rgb_t              pix_rgb;

    // rptr counts pixels, so its upper bits are the word index being read.
    assign wcount = wptr - rptr[AW+1:1];
    assign full   = (wcount == DEPTH_C);
    assign empty  = ({wptr, 1'b0} == rptr);

    assign beat   = RVALID & RREADY;
    assign wr_en  = beat & ~full & ~FLUSH;
    assign pop_ok = PIX_RE & ~empty & ~FLUSH;

    always_comb begin
        wptr_nxt = wptr;
        rptr_nxt = rptr;
        if (FLUSH) begin
            wptr_nxt = '0;
            rptr_nxt = '0;
        end else begin
            if (wr_en)  wptr_nxt = wptr + 1'b1;
            if (pop_ok) rptr_nxt = rptr + 1'b1;
        end
    end

    assign wcount_nxt = wptr_nxt - rptr_nxt[AW+1:1];
    assign free_nxt   = DEPTH_C - wcount_nxt;

    disp_rdbuf_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .ACLK  (ACLK),
        .we    (wr_en),
        .waddr (wptr[AW-1:0]),
        .wdata (RDATA),
        .raddr (rptr[AW:1]),
        .rdata (rd_word)
    );

    assign pix     = rptr[0] ? rd_word[2*PIX_W-1:PIX_W] : rd_word[PIX_W-1:0];
    assign pix_rgb = pix_to_rgb(pix);

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            wptr       <= '0;
            rptr       <= '0;
            BUF_WREADY <= 1'b1;
            BUF_EMPTY  <= 1'b1;
            OVERFLOW   <= 1'b0;
            UNDERRUN   <= 1'b0;
            DISP_R     <= '0;
            DISP_G     <= '0;
            DISP_B     <= '0;
        end else begin
            wptr       <= wptr_nxt;
            rptr       <= rptr_nxt;
            BUF_WREADY <= (free_nxt >= BURST_C);
            BUF_EMPTY  <= ({wptr_nxt, 1'b0} == rptr_nxt);
            if (FLUSH) begin
                OVERFLOW <= 1'b0;
                UNDERRUN <= 1'b0;
                DISP_R   <= '0;
                DISP_G   <= '0;
                DISP_B   <= '0;
            end else begin
                if (beat && full) OVERFLOW <= 1'b1;
                if (PIX_RE) begin
                    if (empty) begin
                        UNDERRUN <= 1'b1;
                        DISP_R   <= '0;
                        DISP_G   <= '0;
                        DISP_B   <= '0;
                    end else begin
                        DISP_R   <= pix_rgb.r;
                        DISP_G   <= pix_rgb.g;
                        DISP_B   <= pix_rgb.b;
                    end
                end
            end
        end
    end

endmodule
